cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter NUM_HW_INT, default 6, meaning external hardware interrupt lines (1..6).
REQ-002 SHALL have parameter COUNT_DIV, default 2, meaning Count increments once per COUNT_DIV clocks (1..16).
REQ-003 SHALL have parameter HAS_TIMER, default 1, meaning the Compare register and timer interrupt are present.
REQ-004 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, meaning the exception entry address.
REQ-005 SHALL have the clock port `clk`, input, 1 bit, as the single clock; every register SHALL update on its rising edge.
REQ-006 SHALL have the reset port `rst`, input, 1 bit, asynchronous and active-low.
REQ-007 SHALL have `ext_int`, input, NUM_HW_INT bits, level-sensitive hardware interrupts.
REQ-008 SHALL have `stall`, input, 1 bit, commit stage frozen.
REQ-009 SHALL have `commit_valid`, input, 1 bit, a valid instruction is at commit.
REQ-010 SHALL have `commit_pc`, input, 32 bits.
REQ-011 SHALL have `commit_bd`, input, 1 bit, the committing instruction is in a delay slot.
REQ-012 SHALL have `exc_req`, input, 1 bit, the committing instruction raised a synchronous exception.
REQ-013 SHALL have `exc_code`, input, 5 bits, the ExcCode of that exception.
REQ-014 SHALL have `exc_badvaddr`, input, 32 bits, the faulting address.
REQ-015 SHALL have `exc_addr_err`, input, 1 bit, exc_badvaddr is meaningful.
REQ-016 SHALL have `eret`, input, 1 bit, ERET is committing.
REQ-017 SHALL have `mtc0_we`, input, 1 bit, MTC0 is committing.
REQ-018 SHALL have `cp0_waddr`, input, 5 bits, the MTC0 target register.
REQ-019 SHALL have `cp0_wsel`, input, 3 bits, the MTC0 select.
REQ-020 SHALL have `cp0_wdata`, input, 32 bits, the MTC0 data.
REQ-021 SHALL have `cp0_raddr`, input, 5 bits, the MFC0 register.
REQ-022 SHALL have `cp0_rsel`, input, 3 bits, the MFC0 select.
REQ-023 SHALL have `cp0_rdata`, output, 32 bits, combinational MFC0 data.
REQ-024 SHALL have `flush`, output, 1 bit, a one-cycle pipeline flush/redirect pulse.
REQ-025 SHALL have `redirect_pc`, output, 32 bits, the redirect target.
REQ-026 SHALL have `timer_int`, output, 1 bit, which mirrors Cause.TI.

Function
REQ-027 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14), all at sel 0; every other reg/sel SHALL read 0 and ignore writes.
REQ-028 Status SHALL keep bit22 (BEV) reading 1, bits 15:8 (IM) and 1:0 (EXL, IE) writable, and all other bits reading 0.
REQ-029 Cause SHALL have: bit31 BD, bit30 TI, bits 15:10 = {TI|ext_int[5], ext_int[4:0]} sampled each cycle, bits 9:8 writable, bits 6:2 ExcCode; unused IP bits (NUM_HW_INT<6) SHALL read 0.
REQ-030 In the timer path, Count SHALL increment by 1, wrapping at 2^32, every COUNT_DIV cycles regardless of stall.
REQ-031 When Count==Compare, TI SHALL set on the following edge.
REQ-032 An MTC0 to Compare SHALL clear TI; with HAS_TIMER=0, TI SHALL be tied 0 and Compare SHALL read 0.
REQ-033 An MTC0 to Count SHALL load the value and restart the prescaler; this write SHALL win over an increment in the same cycle.
REQ-034 An interrupt SHALL be pending when Status.IE=1, EXL=0 and (Cause.IP & Status.IM)!=0.
REQ-035 When commit_valid=1 and stall=0, the committing event SHALL be resolved by priority: pending interrupt > exc_req > eret > mtc0_we.
REQ-036 On interrupt or exception entry: EXL<=1; BD<=commit_bd; EPC<=commit_bd ? commit_pc-4 : commit_pc; ExcCode<=0 for an interrupt, else exc_code; BadVAddr<=exc_badvaddr only if exc_addr_err.
REQ-037 On entry, flush SHALL pulse for 1 cycle with redirect_pc=EXC_VECTOR.
REQ-038 While EXL=1, an exception arriving SHALL still redirect and update ExcCode, but EPC and BD SHALL be held.
REQ-039 ERET SHALL set EXL<=0 and pulse flush with redirect_pc=EPC (the value before that edge).
REQ-040 An MTC0 losing arbitration SHALL be dropped.
REQ-041 While stall=1 or commit_valid=0, no architectural state except Count/TI/IP SHALL change, and flush SHALL be 0.
REQ-042 cp0_rdata SHALL return the current register value without write bypass.

Reset
REQ-043 On rst low, asynchronously: Status=0x00400000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, prescaler=0, flush=0, redirect_pc=0, timer_int=0.
REQ-044 Reset mid-flush SHALL kill the pulse immediately.

Structure
REQ-045 A shared package SHALL hold the register-number constants, ExcCode constants (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12) and the Status/Cause bit-position constants.
REQ-046 A single sub-module, cp0_timer (Count, prescaler, Compare, TI), SHALL be instantiated under HAS_TIMER.

Verification
REQ-047 Reset, then read reg 12 -> 0x00400000; read reg 13 -> 0.
REQ-048 MTC0 Compare=10 with COUNT_DIV=2 -> TI and timer_int rise after Count reaches 10 (about 21 cycles); MTC0 Compare=50 -> TI clears next cycle.
REQ-049 Status=0x00008001, ext_int[5]=1, commit_pc=0x80001000, bd=0 -> flush with redirect_pc 0xBFC00380, EPC=0x80001000, ExcCode=0, EXL=1.
REQ-050 exc_req with code 4, bd=1, pc=0x80002004, badvaddr=0x1003 -> EPC=0x80002000, BD=1, BadVAddr=0x1003.
REQ-051 Same-cycle pending interrupt, exc_req and mtc0 -> interrupt taken, the MTC0 is dropped, and ExcCode=0.
REQ-052 stall=1 held with exc_req -> no flush and no EPC change; on release, entry occurs; a following eret -> redirect_pc=EPC and EXL=0.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// Shared constants for the CP0 unit: register numbers, ExcCodes and field positions.
package cp0_unit_pkg;

    // CP0 register numbers (all implemented registers live at select 0)
    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;

    // ExcCode values
    localparam logic [4:0] ExcInt  = 5'd0;
    localparam logic [4:0] ExcAdEL = 5'd4;
    localparam logic [4:0] ExcAdES = 5'd5;
    localparam logic [4:0] ExcSys  = 5'd8;
    localparam logic [4:0] ExcBp   = 5'd9;
    localparam logic [4:0] ExcRI   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

    // Status / Cause field positions
    localparam int unsigned StatusBev  = 22;
    localparam int unsigned StatusImLo = 8;
    localparam int unsigned StatusExl  = 1;
    localparam int unsigned StatusIe   = 0;
    localparam int unsigned CauseBd    = 31;
    localparam int unsigned CauseTi    = 30;
    localparam int unsigned CauseIpLo  = 8;
    localparam int unsigned CauseExcLo = 2;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare match sets TI.
module cp0_timer
    import cp0_unit_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam logic [3:0] PrescMax = 4'(COUNT_DIV - 1);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [3:0]  presc_q, presc_d;
    logic        ti_q, ti_d;

    // Next-state: Count write beats the prescaled increment; Compare write clears TI.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        presc_d   = presc_q;
        ti_d      = ti_q;
        if (count_we_i) begin
            count_d = wdata_i;
            presc_d = 4'd0;
        end else if (presc_q == PrescMax) begin
            count_d = count_q + 32'd1;
            presc_d = 4'd0;
        end else begin
            presc_d = presc_q + 4'd1;
        end
        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            presc_q   <= 4'd0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            presc_q   <= presc_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// MIPS-style CP0: Status/Cause/EPC/BadVAddr, commit-time exception arbitration, timer.
module cp0_unit #(
    parameter int unsigned NUM_HW_INT = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter bit          HAS_TIMER  = 1'b1,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] ext_int,
    input  logic                  stall,
    input  logic                  commit_valid,
    input  logic [31:0]           commit_pc,
    input  logic                  commit_bd,
    input  logic                  exc_req,
    input  logic [4:0]            exc_code,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  exc_addr_err,
    input  logic                  eret,
    input  logic                  mtc0_we,
    input  logic [4:0]            cp0_waddr,
    input  logic [2:0]            cp0_wsel,
    input  logic [31:0]           cp0_wdata,
    input  logic [4:0]            cp0_raddr,
    input  logic [2:0]            cp0_rsel,
    output logic [31:0]           cp0_rdata,
    output logic                  flush,
    output logic [31:0]           redirect_pc,
    output logic                  timer_int
);
    import cp0_unit_pkg::*;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;

    logic [5:0]  ext_pad;
    logic [7:0]  ip_val;
    logic [31:0] status_val, cause_val, count_val, compare_val;
    logic        ti, pending, act, take_int, take_exc, take_eret, take_mtc0;
    logic        count_we, compare_we;

    // Zero-extend the hardware interrupt lines to the six IP slots
    always_comb begin
        ext_pad                 = '0;
        ext_pad[NUM_HW_INT-1:0] = ext_int;
    end

    assign ip_val     = {ip_hw_q, ip_sw_q};
    assign status_val = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti, 14'd0, ip_val, 1'b0, exc_code_q, 2'b00};
    assign pending    = ie_q & ~exl_q & (|(ip_val & im_q));

    // Commit-stage arbitration: interrupt > exception > eret > mtc0
    assign act       = commit_valid & ~stall;
    assign take_int  = act & pending;
    assign take_exc  = act & ~pending & exc_req;
    assign take_eret = act & ~pending & ~exc_req & eret;
    assign take_mtc0 = act & ~pending & ~exc_req & ~eret & mtc0_we & (cp0_wsel == 3'd0);

    assign count_we   = take_mtc0 & (cp0_waddr == RegCount);
    assign compare_we = take_mtc0 & (cp0_waddr == RegCompare);

    if (HAS_TIMER) begin : g_timer
        cp0_timer #(
            .COUNT_DIV(COUNT_DIV)
        ) u_timer (
            .clk         (clk),
            .rst         (rst),
            .count_we_i  (count_we),
            .compare_we_i(compare_we),
            .wdata_i     (cp0_wdata),
            .count_o     (count_val),
            .compare_o   (compare_val),
            .ti_o        (ti)
        );
    end else begin : g_no_timer
        assign count_val   = 32'd0;
        assign compare_val = 32'd0;
        assign ti          = 1'b0;
    end

    // Next architectural state from the winning commit event
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_hw_d    = {ti | ext_pad[5], ext_pad[4:0]};
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        if (take_int || take_exc) begin
            exl_d = 1'b1;
            // A nested exception redirects but keeps the original return context
            if (!exl_q) begin
                bd_d  = commit_bd;
                epc_d = commit_bd ? (commit_pc - 32'd4) : commit_pc;
            end
            exc_code_d = take_int ? ExcInt : exc_code;
            if (take_exc && exc_addr_err) begin
                badvaddr_d = exc_badvaddr;
            end
            flush_d    = 1'b1;
            redirect_d = EXC_VECTOR;
        end else if (take_eret) begin
            exl_d      = 1'b0;
            flush_d    = 1'b1;
            redirect_d = epc_q;
        end else if (take_mtc0) begin
            case (cp0_waddr)
                RegStatus: begin
                    im_d  = cp0_wdata[15:8];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                RegCause: ip_sw_d = cp0_wdata[9:8];
                RegEpc:   epc_d   = cp0_wdata;
                default: ;
            endcase
        end
    end

    // Architectural registers and the registered flush pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            flush_q    <= 1'b0;
            redirect_q <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    // MFC0 read mux, no write bypass
    always_comb begin
        cp0_rdata = 32'd0;
        if (cp0_rsel == 3'd0) begin
            case (cp0_raddr)
                RegBadVAddr: cp0_rdata = badvaddr_q;
                RegCount:    cp0_rdata = count_val;
                RegCompare:  cp0_rdata = compare_val;
                RegStatus:   cp0_rdata = status_val;
                RegCause:    cp0_rdata = cause_val;
                RegEpc:      cp0_rdata = epc_q;
                default:     cp0_rdata = 32'd0;
            endcase
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign timer_int   = ti;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus a randomized commit stream.
module tb_cp0_unit;

    localparam int unsigned CountDiv = 2;
    localparam logic [31:0] Vec = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  ext_int = '0;
    logic        stall = 0, commit_valid = 0, commit_bd = 0, exc_req = 0;
    logic [31:0] commit_pc = 0, exc_badvaddr = 0, cp0_wdata = 0;
    logic [4:0]  exc_code = 0, cp0_waddr = 0, cp0_raddr = 0;
    logic        exc_addr_err = 0, eret = 0, mtc0_we = 0;
    logic [2:0]  cp0_wsel = 0, cp0_rsel = 0;
    logic [31:0] cp0_rdata, redirect_pc;
    logic        flush, timer_int;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cp0_unit #(
        .NUM_HW_INT(6),
        .COUNT_DIV (CountDiv),
        .HAS_TIMER (1'b1),
        .EXC_VECTOR(Vec)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_int     (ext_int),
        .stall       (stall),
        .commit_valid(commit_valid),
        .commit_pc   (commit_pc),
        .commit_bd   (commit_bd),
        .exc_req     (exc_req),
        .exc_code    (exc_code),
        .exc_badvaddr(exc_badvaddr),
        .exc_addr_err(exc_addr_err),
        .eret        (eret),
        .mtc0_we     (mtc0_we),
        .cp0_waddr   (cp0_waddr),
        .cp0_wsel    (cp0_wsel),
        .cp0_wdata   (cp0_wdata),
        .cp0_raddr   (cp0_raddr),
        .cp0_rsel    (cp0_rsel),
        .cp0_rdata   (cp0_rdata),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .timer_int   (timer_int)
    );

    always #10 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        cp0_raddr = a;
        cp0_rsel  = 3'd0;
        #1;
        v = cp0_rdata;
    endtask

    task automatic clear_in();
        stall = 0; commit_valid = 0; commit_bd = 0; exc_req = 0; eret = 0; mtc0_we = 0;
        exc_addr_err = 0; exc_code = 0; cp0_wsel = 0;
    endtask

    task automatic apply_reset();
        clear_in();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        clear_in();
        commit_valid = 1; mtc0_we = 1; cp0_waddr = a; cp0_wsel = 0; cp0_wdata = d;
        cycle();
        clear_in();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear_in();
        rst = 1'b0;
        #3;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; rd(12, v);
        if (v !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status got %h want 00400000", v); end
        n_tests++; rd(13, v);
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_cause got %h want 0", v); end
        n_tests++; rd(14, v);
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want 0", v); end
        n_tests++; rd(8, v);
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_badvaddr got %h want 0", v); end
        n_tests++; rd(9, v);
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h want 0", v); end
        n_tests++; rd(11, v);
        if (v !== 32'h0) begin n_fail++; $display("FAIL reset_compare got %h want 0", v); end
        n_tests++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0 || timer_int !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got flush=%b pc=%h ti=%b want 0/0/0",
                     flush, redirect_pc, timer_int);
        end
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_timer();
        logic [31:0] v;
        int hit;
        apply_reset();
        mtc0(11, 32'd10);
        mtc0(9, 32'd0);
        hit = -1;
        for (int n = 1; n <= 40; n++) begin
            cycle();
            if (timer_int === 1'b1) begin hit = n; break; end
        end
        n_tests++;
        if (hit != 21) begin n_fail++; $display("FAIL timer_rise cycle got %0d want 21", hit); end
        n_tests++; rd(13, v);
        if (v[30] !== 1'b1) begin n_fail++; $display("FAIL timer_cause_ti got %b want 1", v[30]); end
        n_tests++; rd(9, v);
        if (v !== 32'd10) begin n_fail++; $display("FAIL timer_count got %0d want 10", v); end
        mtc0(11, 32'd50);
        n_tests++;
        if (timer_int !== 1'b0) begin n_fail++; $display("FAIL timer_clear got %b want 0", timer_int); end
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        apply_reset();
        mtc0(11, 32'hFFFF_FFFF);
        ext_int = 6'b100000;
        mtc0(12, 32'h0000_8001);
        cycle();
        commit_valid = 1; commit_pc = 32'h8000_1000; commit_bd = 0;
        cycle();
        clear_in();
        n_tests++;
        if (flush !== 1'b1 || redirect_pc !== Vec) begin
            n_fail++; $display("FAIL int_flush got %b/%h want 1/%h", flush, redirect_pc, Vec);
        end
        n_tests++; rd(14, v);
        if (v !== 32'h8000_1000) begin n_fail++; $display("FAIL int_epc got %h want 80001000", v); end
        n_tests++; rd(13, v);
        if (v[6:2] !== 5'd0 || v[15] !== 1'b1) begin
            n_fail++; $display("FAIL int_cause got %h want code 0 ip7 1", v);
        end
        n_tests++; rd(12, v);
        if (v !== 32'h0040_8003) begin n_fail++; $display("FAIL int_status got %h want 00408003", v); end
        cycle();
        n_tests++;
        if (flush !== 1'b0) begin n_fail++; $display("FAIL int_pulse_width got %b want 0", flush); end
        ext_int = '0;
    endtask

    task automatic test_exception();
        logic [31:0] v;
        apply_reset();
        mtc0(11, 32'hFFFF_FFFF);
        commit_valid = 1; exc_req = 1; exc_code = 5'd4; commit_bd = 1;
        commit_pc = 32'h8000_2004; exc_badvaddr = 32'h1003; exc_addr_err = 1;
        cycle();
        clear_in();
        n_tests++;
        if (flush !== 1'b1 || redirect_pc !== Vec) begin
            n_fail++; $display("FAIL exc_flush got %b/%h want 1/%h", flush, redirect_pc, Vec);
        end
        n_tests++; rd(14, v);
        if (v !== 32'h8000_2000) begin n_fail++; $display("FAIL exc_epc got %h want 80002000", v); end
        n_tests++; rd(13, v);
        if (v[31] !== 1'b1 || v[6:2] !== 5'd4) begin
            n_fail++; $display("FAIL exc_cause got %h want bd 1 code 4", v);
        end
        n_tests++; rd(8, v);
        if (v !== 32'h1003) begin n_fail++; $display("FAIL exc_badvaddr got %h want 1003", v); end
        // Nested exception while EXL=1: redirect and code update only
        commit_valid = 1; exc_req = 1; exc_code = 5'd10; commit_bd = 0;
        commit_pc = 32'h8000_3000; exc_addr_err = 0;
        cycle();
        clear_in();
        n_tests++;
        if (flush !== 1'b1) begin n_fail++; $display("FAIL nested_flush got %b want 1", flush); end
        n_tests++; rd(14, v);
        if (v !== 32'h8000_2000) begin n_fail++; $display("FAIL nested_epc got %h want 80002000", v); end
        n_tests++; rd(13, v);
        if (v[31] !== 1'b1 || v[6:2] !== 5'd10) begin
            n_fail++; $display("FAIL nested_cause got %h want bd 1 code 10", v);
        end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        apply_reset();
        mtc0(11, 32'hFFFF_FFFF);
        ext_int = 6'b100000;
        mtc0(12, 32'h0000_8001);
        cycle();
        commit_valid = 1; commit_pc = 32'h8000_4000; exc_req = 1; exc_code = 5'd12;
        mtc0_we = 1; cp0_waddr = 14; cp0_wdata = 32'h1234_5678;
        cycle();
        clear_in();
        n_tests++;
        if (flush !== 1'b1) begin n_fail++; $display("FAIL prio_flush got %b want 1", flush); end
        n_tests++; rd(13, v);
        if (v[6:2] !== 5'd0) begin n_fail++; $display("FAIL prio_code got %0d want 0", v[6:2]); end
        n_tests++; rd(14, v);
        if (v !== 32'h8000_4000) begin n_fail++; $display("FAIL prio_epc got %h want 80004000", v); end
        ext_int = '0;
    endtask

    task automatic test_stall();
        logic [31:0] v;
        apply_reset();
        mtc0(11, 32'hFFFF_FFFF);
        commit_valid = 1; stall = 1; exc_req = 1; exc_code = 5'd8; commit_pc = 32'h8000_3000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++; rd(14, v);
            if (flush !== 1'b0 || v !== 32'h0) begin
                n_fail++; $display("FAIL stall_hold got flush=%b epc=%h want 0/0", flush, v);
            end
        end
        stall = 0;
        cycle();
        clear_in();
        n_tests++; rd(14, v);
        if (flush !== 1'b1 || v !== 32'h8000_3000) begin
            n_fail++; $display("FAIL stall_release got flush=%b epc=%h want 1/80003000", flush, v);
        end
        commit_valid = 1; eret = 1;
        cycle();
        clear_in();
        n_tests++;
        if (flush !== 1'b1 || redirect_pc !== 32'h8000_3000) begin
            n_fail++; $display("FAIL eret_redirect got %b/%h want 1/80003000", flush, redirect_pc);
        end
        n_tests++; rd(12, v);
        if (v[1] !== 1'b0) begin n_fail++; $display("FAIL eret_exl got %b want 0", v[1]); end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        commit_valid = 1; exc_req = 1; exc_code = 5'd9; commit_pc = 32'h8000_5000;
        cycle();
        clear_in();
        rst = 1'b0;
        #1;
        n_tests++;
        if (flush !== 1'b0 || redirect_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_kill got %b/%h want 0/0", flush, redirect_pc);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [4:0]  addrs [5];
        logic [4:0]  codes [6];
        logic [7:0]  m_im;
        logic        m_exl, m_ie, m_bd;
        logic [1:0]  m_sw;
        logic [4:0]  m_code;
        logic [31:0] m_epc, m_bva, exp_redir, v, exp_v;
        logic [5:0]  m_ext;
        logic        sv, cv, er, et, mt, bd, ae, pend, exp_flush;
        logic [4:0]  a, code;
        logic [2:0]  sel;
        logic [31:0] d, pc, bva;
        int base;
        addrs = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd3};
        codes = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
        apply_reset();
        mtc0(11, 32'hFFFF_FFFF);
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_sw = 0; m_code = 0; m_epc = 0; m_bva = 0;
        m_ext = 6'($urandom);
        ext_int = m_ext;
        mtc0(9, 32'd0);
        base = cyc;
        for (int it = 0; it < 200; it++) begin
            if (it % 40 == 39) begin
                m_ext = 6'($urandom);
                ext_int = m_ext;
                clear_in();
                cycle();
            end
            sv = ($urandom % 4) == 0;  cv = ($urandom % 4) != 0;
            er = ($urandom % 3) == 0;  et = ($urandom % 4) == 0;
            mt = ($urandom % 3) == 0;  a = addrs[$urandom % 5];
            sel = (($urandom % 6) == 0) ? 3'd1 : 3'd0;
            d = $urandom; pc = $urandom & 32'hFFFF_FFFC; bd = 1'($urandom);
            code = codes[$urandom % 6]; ae = 1'($urandom); bva = $urandom;
            stall = sv; commit_valid = cv; exc_req = er; eret = et; mtc0_we = mt;
            cp0_waddr = a; cp0_wsel = sel; cp0_wdata = d; commit_pc = pc; commit_bd = bd;
            exc_code = code; exc_addr_err = ae; exc_badvaddr = bva;
            // Reference model of the commit event
            pend = m_ie && !m_exl && ((({m_ext, m_sw}) & m_im) != 8'd0);
            exp_flush = 0; exp_redir = 0;
            if (cv && !sv) begin
                if (pend || er) begin
                    if (!m_exl) begin m_bd = bd; m_epc = bd ? pc - 32'd4 : pc; end
                    m_exl = 1;
                    m_code = pend ? 5'd0 : code;
                    if (!pend && ae) m_bva = bva;
                    exp_flush = 1; exp_redir = Vec;
                end else if (et) begin
                    exp_flush = 1; exp_redir = m_epc; m_exl = 0;
                end else if (mt && sel == 3'd0) begin
                    if (a == 5'd12) begin m_im = d[15:8]; m_exl = d[1]; m_ie = d[0]; end
                    else if (a == 5'd13) m_sw = d[9:8];
                    else if (a == 5'd14) m_epc = d;
                end
            end
            cycle();
            n_tests++;
            if (flush !== exp_flush || (exp_flush && redirect_pc !== exp_redir)) begin
                n_fail++;
                $display("FAIL rnd_flush it=%0d got %b/%h want %b/%h", it, flush, redirect_pc,
                         exp_flush, exp_redir);
            end
            n_tests++; rd(12, v);
            exp_v = 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            if (v !== exp_v) begin n_fail++; $display("FAIL rnd_status it=%0d got %h want %h", it, v, exp_v); end
            n_tests++; rd(13, v);
            exp_v = (32'(m_bd) << 31) | (32'(m_ext) << 10) | (32'(m_sw) << 8) | (32'(m_code) << 2);
            if (v !== exp_v) begin n_fail++; $display("FAIL rnd_cause it=%0d got %h want %h", it, v, exp_v); end
            n_tests++; rd(14, v);
            if (v !== m_epc) begin n_fail++; $display("FAIL rnd_epc it=%0d got %h want %h", it, v, m_epc); end
            n_tests++; rd(8, v);
            if (v !== m_bva) begin n_fail++; $display("FAIL rnd_badvaddr it=%0d got %h want %h", it, v, m_bva); end
            n_tests++; rd(9, v);
            exp_v = 32'((cyc - base) / CountDiv);
            if (v !== exp_v) begin n_fail++; $display("FAIL rnd_count it=%0d got %0d want %0d", it, v, exp_v); end
        end
        clear_in();
        ext_int = '0;
    endtask

    initial begin
        test_reset();
        test_timer();
        test_interrupt();
        test_exception();
        test_priority();
        test_stall();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
